// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads a variable-latency imem over req/ack,
// and buffers {word, pc} pairs in a small FIFO that feeds decode over valid/ready.
module ifetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              AW       = 10,
  parameter logic [15:0]     RESET_PC = 16'h0000
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  input  logic          redirect,
  input  logic [15:0]   redirect_pc,
  output logic          inst_valid,
  output logic [15:0]   inst,
  output logic [15:0]   inst_pc,
  input  logic          inst_ready
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]    state;
  logic [15:0]   fetch_pc;
  logic [AW-1:0] drop_addr;
  logic [PW:0]   count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [15:0]   inst_mem [DEPTH];
  logic [15:0]   pc_mem   [DEPTH];

  logic xfer;
  logic push;
  logic pop;
  logic unused_bits;

  // Request is a pure function of registers, so address and req stay stable until ack.
  assign imem_req  = ((state == S_FETCH) && (count < FULL)) || (state == S_DROP);
  assign imem_addr = (state == S_DROP) ? drop_addr : fetch_pc[AW+1:2];

  assign xfer = imem_req && imem_ack;
  assign push = (state == S_FETCH) && xfer && !redirect;
  assign pop  = inst_valid && inst_ready && !redirect;

  assign inst_valid  = (count != '0);
  assign inst        = inst_mem[rd_ptr];
  assign inst_pc     = pc_mem[rd_ptr];
  assign unused_bits = &{1'b0, redirect_pc[1:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      drop_addr <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else if (redirect) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= {redirect_pc[15:2], 2'b00};
      if (imem_req && !imem_ack) begin
        // An in-flight read must still complete; remember where it went so req stays put.
        state <= S_DROP;
        if (state == S_FETCH) drop_addr <= fetch_pc[AW+1:2];
      end else begin
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: if (push) fetch_pc <= fetch_pc + 16'd4;
        S_DROP:  if (xfer) state <= S_FETCH;
        default: state <= S_IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is reset (not just the pointers) because inst/inst_pc must read 0 after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

endmodule
